memtile_delay_cfg_writer: RTL

MEMTILE_DELAY_CFG_WRITER -- requirements
Module: memtile_delay_cfg_writer

---
 rtl/memtile_delay_cfg_writer.sv | 79 +++++++
 1 files changed

// File: rtl/memtile_delay_cfg_writer.sv
// memtile_delay_cfg_writer: programs an 8-entry memtile delay config over the config bus and verifies it by readback
module memtile_delay_cfg_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] delay,
  input  logic [15:0] range,
  output logic        config_en,
  output logic        config_write,
  output logic        config_read,
  output logic [7:0]  config_addr_in,
  output logic [31:0] config_data_in,
  input  logic [31:0] config_data_out,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  mismatch_addr
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] dly, rng;
  logic [2:0]  idx, chk_idx;
  logic        chk_v, rej, miss;
  logic [31:0] tbl [8];
  // a delay deeper than the 512-entry SRAM or an empty loop cannot be programmed
  assign rej  = delay >= 16'd512 || range == 16'd0;
  assign miss = chk_v && config_data_out != tbl[chk_idx];
  always_comb begin
    tbl[0] = 32'd0;
    tbl[1] = 32'd1;
    tbl[2] = {16'd0, dly};
    tbl[3] = 32'd1;
    tbl[4] = 32'd1;
    tbl[5] = {16'd0, rng};
    tbl[6] = 32'd0;
    tbl[7] = {16'd0, rng};
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (start ? (rej ? DONE : WRITE) : IDLE) :
               state == WRITE ? (idx == 3'd7 ? READ : WRITE) :
               state == READ  ? (idx == 3'd7 ? DRAIN : READ) :
               state == DRAIN ? DONE : IDLE;
  end
  always_comb begin
    config_en      = state == WRITE || state == READ;
    config_write   = state == WRITE;
    config_read    = state == READ;
    config_addr_in = config_en ? {5'd0, idx} : 8'd0;
    config_data_in = config_write ? tbl[idx] : 32'd0;
    busy           = state == WRITE || state == READ || state == DRAIN;
    done           = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      dly           <= '0;
      rng           <= '0;
      idx           <= '0;
      chk_idx       <= '0;
      chk_v         <= 1'b0;
      error         <= 1'b0;
      mismatch_addr <= '0;
    end else begin
      idx     <= config_en ? idx + 3'd1 : 3'd0;
      chk_v   <= config_read;
      chk_idx <= idx;
      if (state == IDLE && start) begin
        dly           <= delay;
        rng           <= range;
        error         <= rej;
        mismatch_addr <= delay >= 16'd512 ? 8'h02 : range == 16'd0 ? 8'h05 : 8'h00;
      end else if (miss && !error) begin
        error         <= 1'b1;
        mismatch_addr <= {5'd0, chk_idx};
      end
    end
  end
endmodule
